// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants, the instruction-class enumeration and the word encoder.
// Latency: none; this file holds only constants and a pure function.
// Backpressure: not applicable.
package instr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [2:0] {
    KIND_RTYPE   = 3'd0,
    KIND_ADDI    = 3'd1,
    KIND_LW      = 3'd2,
    KIND_SW      = 3'd3,
    KIND_BEQ     = 3'd4,
    KIND_ORI     = 3'd5,
    KIND_J       = 3'd6,
    KIND_ILLEGAL = 3'd7
  } kind_e;

  // Fields are packed verbatim; there is no sign extension and no range check.
  // The illegal class encodes as all zeros, which is sll $0,$0,0 (nop).
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    word = 32'h0000_0000;
    case (kind_e'(kind))
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
      KIND_LW:    word = {OP_LW, rs, rt, imm};
      KIND_SW:    word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
      KIND_ORI:   word = {OP_ORI, rs, rt, imm};
      KIND_J:     word = {OP_J, target};
      default:    word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with push/pop/flush, built on extended read/write pointers.
// Latency: a word pushed at edge N becomes visible at the head during the cycle after N; there is no bypass.
// Backpressure: a push while full and a pop while empty are ignored; flush wins over push and pop.
// Ports: clk, rst (async, active-high), flush, push/push_dat, pop, head_dat, full, empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_dat;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB tells a full ring (MSBs differ) from an empty ring (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_dat <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        last_dat <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // While empty, the slot under rd_ptr is stale, so the last retired word is shown instead.
  // After reset that register is zero, which gives a zero head at reset.
  assign head_dat = empty ? last_dat : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into MIPS words and streams them into instruction memory at consecutive addresses.
// Latency: a request accepted at edge N drives mem_we_o with its word during the cycle after N.
// Backpressure: req_ready_o = !full; mem_ready_i low stalls the stream with address and data held steady.
// Ports: clk_i, rst_i (async, active-high), restart_i (sync flush), req_* request handshake with
//   kind/rs/rt/rd/funct/imm/target fields, mem_* write port, count_o, and err_o when ENCODER_CHECK_EN is defined.
// With ENCODER_CHECK_EN defined, illegal kinds are accepted but dropped and set a sticky err_o;
// otherwise they are encoded as a nop.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        restart_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  output logic [31:0] count_o
`ifdef ENCODER_CHECK_EN
  ,
  output logic        err_o
`endif
);

  logic [31:0] enc_word;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  assign enc_word    = encode_instr(kind_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i);
  assign req_ready_o = !full;
  assign mem_we_o    = !empty;
  assign accept      = req_valid_i && req_ready_o && !restart_i;
  assign pop         = mem_we_o && mem_ready_i;

`ifdef ENCODER_CHECK_EN
  logic illegal;
  assign illegal = (kind_i == KIND_ILLEGAL);
  // The handshake still completes for an illegal kind; only the FIFO write is suppressed.
  assign push    = accept && !illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (restart_i) begin
      err_o <= 1'b0;
    end else if (accept && illegal) begin
      err_o <= 1'b1;
    end
  end
`else
  assign push = accept;
`endif

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (restart_i),
    .push     (push),
    .push_dat (enc_word),
    .pop      (pop),
    .head_dat (mem_data_o),
    .full     (full),
    .empty    (empty)
  );

  // Address and count advance only on a retired write and both wrap modulo 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_addr_o <= BASE_ADDR;
      count_o    <= 32'd0;
    end else if (restart_i) begin
      mem_addr_o <= BASE_ADDR;
      count_o    <= 32'd0;
    end else if (pop) begin
      mem_addr_o <= mem_addr_o + 32'd4;
      count_o    <= count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
// Latency: the model predicts each edge from the inputs and then compares outputs 1 time unit after the edge.
// Backpressure: mem_ready_i is toggled to exercise full and stall behaviour.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] count;
`ifdef ENCODER_CHECK_EN
  logic        err;
`endif

  instr_encoder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .restart_i   (restart),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .kind_i      (kind),
    .rs_i        (rs),
    .rt_i        (rt),
    .rd_i        (rd),
    .funct_i     (funct),
    .imm_i       (imm),
    .target_i    (target),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_ready_i (mem_ready),
    .count_o     (count)
`ifdef ENCODER_CHECK_EN
    ,
    .err_o       (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] q[$];
  logic [31:0] m_addr;
  logic [31:0] m_cnt;
  logic        m_err;
  bit          last_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Word assembly from the MIPS field positions using plain arithmetic.
  function automatic logic [31:0] ref_word(input int unsigned k, input int unsigned s, input int unsigned t,
                                           input int unsigned d, input int unsigned fn,
                                           input int unsigned im, input int unsigned tg);
    int unsigned opc[8];
    int unsigned w;
    opc = '{32'h00, 32'h08, 32'h23, 32'h2B, 32'h04, 32'h0D, 32'h02, 32'h00};
    if (k == 0)      w = s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + fn;
    else if (k == 6) w = opc[6] * (1 << 26) + tg;
    else if (k == 7) w = 0;
    else             w = opc[k] * (1 << 26) + s * (1 << 21) + t * (1 << 16) + im;
    return 32'(w);
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = BASE;
    m_cnt  = 32'd0;
    m_err  = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("ready", 32'(req_ready), 32'(q.size() < DEPTH));
    check_eq("we", 32'(mem_we), 32'(q.size() > 0));
    if (q.size() > 0) check_eq("data", mem_data, q[0]);
    check_eq("addr", mem_addr, m_addr);
    check_eq("count", count, m_cnt);
`ifdef ENCODER_CHECK_EN
    check_eq("err", 32'(err), 32'(m_err));
`endif
  endtask

  task automatic set_req(input logic v, input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] fn, input logic [15:0] im,
                         input logic [25:0] tg);
    req_valid = v; kind = k; rs = s; rt = t; rd = d; funct = fn; imm = im; target = tg;
  endtask

  // One clock: predict the edge from the current inputs, advance, then compare.
  task automatic step();
    bit          acc, pop, rsr;
    logic [31:0] w;
    logic [2:0]  k;
    rsr = restart;
    acc = req_valid && (q.size() < DEPTH) && !restart;
    pop = (q.size() > 0) && mem_ready;
    k   = kind;
    w   = ref_word(kind, rs, rt, rd, funct, imm, target);
    @(posedge clk);
    if (rsr) begin
      model_reset();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_addr = m_addr + 32'd4;
        m_cnt  = m_cnt + 32'd1;
      end
      if (acc) begin
`ifdef ENCODER_CHECK_EN
        if (k == 3'd7) m_err = 1'b1;
        else q.push_back(w);
`else
        q.push_back(w);
`endif
      end
    end
    last_acc = acc;
    #1;
    compare_all();
  endtask

  initial begin
    int acc_n;
    int guard;
    rst = 1'b1; restart = 1'b0; mem_ready = 1'b0;
    set_req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    model_reset();
    last_acc = 0;
    @(posedge clk); @(posedge clk); #1;
    // Reset values while reset is held.
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", mem_addr, BASE);
    check_eq("rst_data", mem_data, 32'd0);
    check_eq("rst_count", count, 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
`ifdef ENCODER_CHECK_EN
    check_eq("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;

    // R-type add $3,$1,$2.
    mem_ready = 1'b1;
    set_req(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    step();
    check_eq("t1_we", 32'(mem_we), 32'd1);
    check_eq("t1_addr", mem_addr, 32'h0);
    check_eq("t1_data", mem_data, 32'h0022_1820);
    req_valid = 1'b0;
    step();
    check_eq("t1_count", count, 32'd1);

    // lw then j, back to back.
    model_reset(); restart = 1'b1; step(); restart = 1'b0;
    set_req(1'b1, 3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0);
    step();
    check_eq("t2_lw_data", mem_data, 32'h8C08_0004);
    check_eq("t2_lw_addr", mem_addr, 32'h0);
    set_req(1'b1, 3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0010);
    step();
    check_eq("t2_j_data", mem_data, 32'h0800_0010);
    check_eq("t2_j_addr", mem_addr, 32'h4);
    req_valid = 1'b0;
    step();

    // Stall: six requests with memory not ready.
    restart = 1'b1; step(); restart = 1'b0;
    mem_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 5'($urandom),
              6'($urandom), 16'($urandom), 26'($urandom));
      step();
      if (last_acc) acc_n++;
      if (i == 3) check_eq("t3_full_ready", 32'(req_ready), 32'd0);
    end
    check_eq("t3_accepted", 32'(acc_n), 32'd4);
    check_eq("t3_stall_addr", mem_addr, 32'h0);
    mem_ready = 1'b1;
    guard = 0;
    while (acc_n < 6 && guard < 20) begin
      step();
      if (last_acc) acc_n++;
      guard++;
    end
    check_eq("t3_release_accepts", 32'(acc_n), 32'd6);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("t3_final_count", count, 32'd6);

    // Restart while full with a request offered.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 3'd1, 5'($urandom), 5'($urandom), 5'd0, 6'd0, 16'($urandom), 26'd0);
      step();
    end
    restart = 1'b1;
    step();
    restart = 1'b0; req_valid = 1'b0;
    check_eq("t4_we", 32'(mem_we), 32'd0);
    check_eq("t4_addr", mem_addr, BASE);
    check_eq("t4_count", count, 32'd0);
    check_eq("t4_ready", 32'(req_ready), 32'd1);

    // Illegal kind.
    mem_ready = 1'b1;
    set_req(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 6'h3F, 16'hFFFF, 26'h3FF_FFFF);
    step();
    req_valid = 1'b0;
`ifdef ENCODER_CHECK_EN
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_no_write", 32'(mem_we), 32'd0);
`else
    check_eq("t5_nop_we", 32'(mem_we), 32'd1);
    check_eq("t5_nop_data", mem_data, 32'd0);
`endif
    step();
    restart = 1'b1; step(); restart = 1'b0;

    // Asynchronous reset with three words buffered.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 3'd5, 5'($urandom), 5'($urandom), 5'd0, 6'd0, 16'($urandom), 26'd0);
      step();
    end
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_we", 32'(mem_we), 32'd0);
    check_eq("t6_addr", mem_addr, BASE);
    check_eq("t6_count", count, 32'd0);
    check_eq("t6_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    set_req(1'b1, 3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0);
    step();
    req_valid = 1'b0;
    check_eq("t6_base_addr", mem_addr, BASE);
    check_eq("t6_sw_data", mem_data, 32'hAC85_0010);
    step();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      restart   = ($urandom_range(0, 40) == 0);
      set_req(1'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              6'($urandom), 16'($urandom), 26'($urandom));
      step();
    end
    restart = 1'b0; req_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encoder counterpart to the opcode decoder in the control path. Accepts instruction requests as an instruction class plus register, immediate and target fields, and assembles the 32-bit MIPS word. Buffers encoded words in a small FIFO and streams them into instruction memory at consecutive word addresses. Used by the bench harness and boot loader to build programs for the single-cycle CPU.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: first byte address written after reset or restart.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- restart_i  in  1  synchronous flush: empties the FIFO and sets the address to BASE_ADDR.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request can be accepted; equals !full.
- kind_i  in  3  instruction class: 0 R-type, 1 addi, 2 lw, 3 sw, 4 beq, 5 ori, 6 j, 7 illegal.
- rs_i, rt_i, rd_i  in  5 each  register fields.
- funct_i  in  6  R-type function field.
- imm_i  in  16  I-type immediate.
- target_i  in  26  J-type target.
- mem_we_o  out  1  write strobe; equals !empty.
- mem_addr_o  out  32  byte address of the current write.
- mem_data_o  out  32  encoded word at the FIFO head.
- mem_ready_i  in  1  memory accepts the write this cycle.
- count_o  out  32  words written since reset or restart.
- err_o  out  1  sticky illegal-kind flag; present only when ENCODER_CHECK_EN is defined.

## Operation
- Encoding rules:
  - R-type: {6'h00, rs, rt, rd, 5'b0, funct}.
  - addi, lw, sw, beq, ori: {op, rs, rt, imm}, with op = 08, 23, 2B, 04, 0D (hex) respectively.
  - j: {6'h02, target}.
  - Fields are taken verbatim; there is no sign extension or range checking.
- Push: when req_valid_i && req_ready_o, the encoded word is written to the tail entry.
- Pop: when mem_we_o && mem_ready_i, the head entry is retired, mem_addr_o increments by 4, and count_o increments by 1.
- Read and write pointers are log2(DEPTH)+1 bits; full/empty is decided by comparing the MSB.
- FIFO state is derived from the pointers only; there is no separate FSM.
- mem_addr_o wraps modulo 2^32. count_o wraps modulo 2^32.
- Boundary behaviour:
  - Push and pop in the same cycle while not full: both take effect and occupancy is unchanged.
  - When full, req_ready_o=0, so no push occurs even if a pop happens that cycle. There is no same-cycle bypass.
  - When empty: mem_we_o=0 and mem_data_o holds the last head value. Consumers ignore mem_data_o while mem_we_o=0.
  - restart_i has priority over push and pop in the same cycle. That cycle's request is dropped, and count_o is cleared to 0.
  - Reset mid-stream discards all buffered words. There are no partial writes because every write is a single cycle.
- Reset values:
  - mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, count_o=0.
  - req_ready_o=1; it follows the empty FIFO.
  - err_o=0.

## Timing
- Latency: a request accepted at edge N produces mem_we_o=1 with the matching data during the cycle after N.
- Throughput: one word per cycle when mem_ready_i is held high.
- Holding mem_ready_i low stalls the stream:
  - mem_addr_o and mem_data_o hold steady.
  - The FIFO fills after DEPTH accepts, then req_ready_o falls.
- req_ready_o and mem_we_o are combinational from registered pointers. There is no combinational path from inputs to outputs.

## Configuration
- ENCODER_CHECK_EN defined:
  - kind_i=7 is still accepted (the handshake completes) but pushes nothing.
  - err_o sets and stays set until rst_i or restart_i.
- ENCODER_CHECK_EN undefined:
  - kind_i=7 pushes 32'h0000_0000 (sll $0,$0,0, i.e. nop).
  - The err_o port is absent.

## Structure
- Shared package holds:
  - Opcode constants: OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_ORI=6'h0D, OP_J=6'h02.
  - The 3-bit kind enumeration.
- The control decoder imports the same constants.
- One sub-module: instr_fifo, a parameterised synchronous FIFO with push/pop/flush and full/empty outputs. The encode logic stays combinational in the top.

## Test plan
- After reset, R-type rs=1, rt=2, rd=3, funct=6'h20 with mem_ready_i=1 -> next cycle mem_we_o=1, addr 0x0, data 0x00221820; count_o=1 after the pop.
- lw rs=0, rt=8, imm=16'h0004, then j target=26'h0000010, back-to-back -> data 0x8C080004 at 0x0, then 0x08000010 at 0x4.
- mem_ready_i=0, DEPTH=4, six requests offered -> req_ready_o falls after the 4th accept. On release, 4 writes complete in order at 0x0..0xC, then the remaining 2 are accepted.
- Full FIFO, restart_i together with req_valid_i -> next cycle empty, mem_addr_o=BASE_ADDR, count_o=0, request discarded.
- kind_i=7 -> with ENCODER_CHECK_EN: err_o=1 and no write. Without it: one write of 0x00000000.
- rst_i asserted mid-stream with 3 words buffered -> outputs go to reset values immediately (asynchronously); the next accepted word writes to BASE_ADDR.
